// File: rtl/lcd_nibble_writer.sv
// lcd_nibble_writer: byte-to-pin transmit stage for the 4-bit character LCD bus.
// Takes one {RS, byte} request over valid/ready and sends it as two timed nibble
// writes (high nibble first). It then holds off the next request until the
// LCD's post-command execution time has elapsed.
// Optional feature macro: LCD_NIBBLE_ONLY_EN. When it is defined, iNibbleOnly
// sends the high nibble only, which the power-on init writes need.
module lcd_nibble_writer #(
   parameter int unsigned SETUP_CYC      = 2,
   parameter int unsigned PULSE_CYC      = 12,
   parameter int unsigned HOLD_CYC       = 1,
   parameter int unsigned NIBBLE_GAP_CYC = 50,
   parameter int unsigned BYTE_GAP_CYC   = 2000,
   parameter int unsigned LONG_GAP_CYC   = 82000,
   parameter int unsigned CNT_W          = 17
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       iValid,
   input  logic       iRS,
   input  logic [7:0] iData,
   input  logic       iLongWait,
   input  logic       iNibbleOnly,
   output logic       oReady,
   output logic       oLCD_Enabled,
   output logic       oLCD_RegisterSelect,
   output logic       oLCD_ReadWrite,
   output logic       oLCD_StrataFlashControl,
   output logic [3:0] oLCD_Data
);

   localparam int unsigned NIB_W = 4;

   // Each state lasts (count) cycles, so the down-counter is loaded with count-1.
   localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] NGAP_LOAD   = CNT_W'(NIBBLE_GAP_CYC - 1);
   localparam logic [CNT_W-1:0] BGAP_LOAD   = CNT_W'(BYTE_GAP_CYC - 1);
   localparam logic [CNT_W-1:0] LGAP_LOAD   = CNT_W'(LONG_GAP_CYC - 1);

   typedef enum logic [3:0] {
      IDLE,
      HI_SETUP,
      HI_PULSE,
      HI_HOLD,
      NIBBLE_GAP,
      LO_SETUP,
      LO_PULSE,
      LO_HOLD,
      BYTE_GAP
   } state_t;

   state_t             state, stateNext;
   logic [CNT_W-1:0]   timer, timerNext;
   logic [NIB_W-1:0]   loNibble, loNibbleNext;
   logic               longWait, longWaitNext;
   logic               readyNext, enableNext, rsNext;
   logic [NIB_W-1:0]   dataNext;
   logic               accept;
   logic               skipLow;
   logic [CNT_W-1:0]   gapLoad;

   assign accept  = iValid && oReady;
   assign gapLoad = longWait ? LGAP_LOAD : BGAP_LOAD;

`ifdef LCD_NIBBLE_ONLY_EN
   logic nibbleOnly;

   // Capture the nibble-only request flag at accept.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         nibbleOnly <= 1'b0;
      end else if (accept) begin
         nibbleOnly <= iNibbleOnly;
      end
   end

   assign skipLow = nibbleOnly;
`else
   logic unusedNibbleOnly;
   assign unusedNibbleOnly = iNibbleOnly;
   assign skipLow          = 1'b0;
`endif

   // State, timer, captured request and registered pin outputs.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state                   <= IDLE;
         timer                   <= '0;
         loNibble                <= '0;
         longWait                <= 1'b0;
         oReady                  <= 1'b1;
         oLCD_Enabled            <= 1'b0;
         oLCD_RegisterSelect     <= 1'b0;
         oLCD_ReadWrite          <= 1'b0;
         oLCD_StrataFlashControl <= 1'b1;
         oLCD_Data               <= '0;
      end else begin
         state                   <= stateNext;
         timer                   <= timerNext;
         loNibble                <= loNibbleNext;
         longWait                <= longWaitNext;
         oReady                  <= readyNext;
         oLCD_Enabled            <= enableNext;
         oLCD_RegisterSelect     <= rsNext;
         oLCD_ReadWrite          <= 1'b0;
         oLCD_StrataFlashControl <= 1'b1;
         oLCD_Data               <= dataNext;
      end
   end

   // Next state, timer reload and next pin values; data/RS only change on
   // entry to a *_SETUP state so they stay frozen through pulse and hold.
   always_comb begin
      stateNext    = state;
      timerNext    = timer;
      loNibbleNext = loNibble;
      longWaitNext = longWait;
      rsNext       = oLCD_RegisterSelect;
      dataNext     = oLCD_Data;

      unique case (state)
         IDLE: begin
            if (accept) begin
               stateNext    = HI_SETUP;
               timerNext    = SETUP_LOAD;
               dataNext     = iData[7:4];
               rsNext       = iRS;
               loNibbleNext = iData[3:0];
               longWaitNext = iLongWait;
            end
         end
         HI_SETUP: begin
            if (timer != '0) begin
               timerNext = timer - CNT_W'(1);
            end else begin
               stateNext = HI_PULSE;
               timerNext = PULSE_LOAD;
            end
         end
         HI_PULSE: begin
            if (timer != '0) begin
               timerNext = timer - CNT_W'(1);
            end else begin
               stateNext = HI_HOLD;
               timerNext = HOLD_LOAD;
            end
         end
         HI_HOLD: begin
            if (timer != '0) begin
               timerNext = timer - CNT_W'(1);
            end else if (skipLow) begin
               stateNext = BYTE_GAP;
               timerNext = gapLoad;
            end else begin
               stateNext = NIBBLE_GAP;
               timerNext = NGAP_LOAD;
            end
         end
         NIBBLE_GAP: begin
            if (timer != '0) begin
               timerNext = timer - CNT_W'(1);
            end else begin
               stateNext = LO_SETUP;
               timerNext = SETUP_LOAD;
               dataNext  = loNibble;
            end
         end
         LO_SETUP: begin
            if (timer != '0) begin
               timerNext = timer - CNT_W'(1);
            end else begin
               stateNext = LO_PULSE;
               timerNext = PULSE_LOAD;
            end
         end
         LO_PULSE: begin
            if (timer != '0) begin
               timerNext = timer - CNT_W'(1);
            end else begin
               stateNext = LO_HOLD;
               timerNext = HOLD_LOAD;
            end
         end
         LO_HOLD: begin
            if (timer != '0) begin
               timerNext = timer - CNT_W'(1);
            end else begin
               stateNext = BYTE_GAP;
               timerNext = gapLoad;
            end
         end
         BYTE_GAP: begin
            if (timer != '0) begin
               timerNext = timer - CNT_W'(1);
            end else begin
               stateNext = IDLE;
               timerNext = '0;
            end
         end
         default: begin
            stateNext = IDLE;
            timerNext = '0;
         end
      endcase

      enableNext = (stateNext == HI_PULSE) || (stateNext == LO_PULSE);
      readyNext  = (stateNext == IDLE);
   end

endmodule
